// File: rtl/core_wb_pkg.sv
// Writeback stage shared types.
// Source selects, load sizes and FSM states.
package core_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/core_load_align.sv
// Load data alignment and extension.
// Pure combinational, RV32 only.
module core_load_align
  import core_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_w = rdata_i[15:8];
      2'd2:    byte_w = rdata_i[23:16];
      2'd3:    byte_w = rdata_i[31:24];
      default: byte_w = rdata_i[7:0];
    endcase
    half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      LD_B: data_o = {{(XLEN-8){byte_w[7] & ~unsigned_i}}, byte_w};
      LD_H: data_o = {{(XLEN-16){half_w[15] & ~unsigned_i}}, half_w};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/core_writeback_unit.sv
// Writeback stage: source select, load wait FSM,
// registered register-file write port.
module core_writeback_unit
  import core_wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              rd_we_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_unsigned_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              busy_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]   data_o
);

  wb_state_e         state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [REG_AW-1:0] p_rd_q, p_rd_d;
  logic              p_we_q, p_we_d;
  logic [1:0]        p_off_q, p_off_d;
  logic [1:0]        p_size_q, p_size_d;
  logic              p_uns_q, p_uns_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;

  logic            accept, is_load, wr_en;
  logic [1:0]      al_off, al_size;
  logic            al_uns;
  logic [XLEN-1:0] al_data;

  assign busy_o  = (state_q == WAIT_LOAD);
  assign accept  = valid_i & ~flush_i & ~stall_i & ~busy_o;
  assign is_load = (wb_sel_i == WB_LOAD);
  assign wr_en   = rd_we_i & (rd_addr_i != '0);

  // Outstanding loads align with the attributes latched at accept.
  assign al_off  = busy_o ? p_off_q  : alu_result_i[1:0];
  assign al_size = busy_o ? p_size_q : ld_size_i;
  assign al_uns  = busy_o ? p_uns_q  : ld_unsigned_i;

  core_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i    (dmem_rdata_i),
    .off_i      (al_off),
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .data_o     (al_data)
  );

  always_comb begin
    state_d   = state_q;
    rf_we_d   = rf_we_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    p_rd_d    = p_rd_q;
    p_we_d    = p_we_q;
    p_off_d   = p_off_q;
    p_size_d  = p_size_q;
    p_uns_d   = p_uns_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    case (state_q)
      IDLE: begin
        if (!stall_i) begin
          rf_we_d = 1'b0;
          if (accept && is_load && !dmem_rvalid_i) begin
            p_rd_d   = rd_addr_i;
            p_we_d   = wr_en;
            p_off_d  = alu_result_i[1:0];
            p_size_d = ld_size_i;
            p_uns_d  = ld_unsigned_i;
            state_d  = WAIT_LOAD;
          end else if (accept) begin
            rf_we_d   = wr_en;
            rd_addr_d = rd_addr_i;
            if (is_load)
              data_d = al_data;
            else if (wb_sel_i == WB_PC4)
              data_d = pc_plus4_i;
            else
              data_d = alu_result_i;
          end
        end
      end
      WAIT_LOAD: begin
        // First response wins; later pulses while stalled are ignored.
        if (!buf_vld_q && dmem_rvalid_i) begin
          buf_d     = al_data;
          buf_vld_d = 1'b1;
        end
        if (!stall_i && (buf_vld_q || dmem_rvalid_i)) begin
          rf_we_d   = p_we_q;
          rd_addr_d = p_rd_q;
          data_d    = buf_vld_q ? buf_q : al_data;
          buf_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      rf_we_q   <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      p_rd_q    <= '0;
      p_we_q    <= 1'b0;
      p_off_q   <= '0;
      p_size_q  <= '0;
      p_uns_q   <= 1'b0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= rf_we_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      p_rd_q    <= p_rd_d;
      p_we_q    <= p_we_d;
      p_off_q   <= p_off_d;
      p_size_q  <= p_size_d;
      p_uns_q   <= p_uns_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rd_addr_o = rd_addr_q;
  assign data_o    = data_q;

endmodule
